// File: rtl/serial_addsub.sv
// Multi-cycle WIDTH-bit add/subtract unit. It feeds two operand bits per clock
// through one 2-bit ripple slice and keeps the carry in a single flop.
module serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("serial_addsub: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The 2-bit ripple slice: returns {carry, sum[1:0]}.
  function automatic logic [2:0] add2(input logic [1:0] x, input logic [1:0] y,
                                      input logic cin);
    logic c1;
    logic [2:0] r;
    c1   = (x[0] & y[0]) | (cin & (x[0] ^ y[0]));
    r[0] = x[0] ^ y[0] ^ cin;
    r[1] = x[1] ^ y[1] ^ c1;
    r[2] = (x[1] & y[1]) | (c1 & (x[1] ^ y[1]));
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       slice_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    slice_s  = add2(a_q[1:0], b_q[1:0], carry_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum digits enter at the top so the LSB digit ends up at bit 0.
        acc_d   = {slice_s[1:0], acc_q[WIDTH-1:2]};
        a_d     = {2'b00, a_q[WIDTH-1:2]};
        b_d     = {2'b00, b_q[WIDTH-1:2]};
        carry_d = slice_s[2];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = acc_d;
          cout_d   = slice_s[2];
          // On the last digit a_q[1]/b_q[1] are the operand sign bits.
          ovf_d    = (a_q[1] == b_q[1]) && (slice_s[1] != a_q[1]);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized self-checking bench for serial_addsub against an arithmetic
// reference model (wide add with signed-overflow rule).
module tb_serial_addsub;

  localparam int W    = 32;
  localparam int HALF = W / 2;

  logic         clk = 1'b0;
  logic         rst, start, op_sub;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a + b or a - b modulo 2^W, carry = bit W of a + b' + cin.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] wide;
    if (ms) wide = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else    wide = {1'b0, ma} + {1'b0, mb};
    r = wide[W-1:0];
    c = wide[W];
    if (ms) v = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
    else    v = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
  endtask

  // Runs one operation from IDLE; optionally pokes start during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input bit poke, output int done_cyc);
    logic [W-1:0] er, prev;
    logic         ec, ev;
    int           busy_cycles;
    bit           stable;
    model(ta, tb_v, ts, er, ec, ev);
    prev   = result;
    a      = ta;
    b      = tb_v;
    op_sub = ts;
    start  = 1'b1;
    step();
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    op_sub = 1'($urandom_range(1, 0));
    busy_cycles = 0;
    stable      = 1'b1;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      if (result !== prev || done) stable = 1'b0;
      if (poke && busy_cycles == 3) begin
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd200;
      end
      step();
    end
    start    = 1'b0;
    done_cyc = cyc;
    check("busy_cycles", 64'(busy_cycles), 64'(HALF));
    check("held_during_run", 64'(stable), 64'd1);
    check("done", 64'(done), 64'd1);
    check("result", 64'(result), 64'(er));
    check("carry_out", 64'(carry_out), 64'(ec));
    check("overflow", 64'(overflow), 64'(ev));
    check("zero", 64'(zero), 64'(er == '0));
    step();
    check("done_pulse_end", 64'(done), 64'd0);
    check("result_hold", 64'(result), 64'(er));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d1, d2, dones;
    logic [W-1:0] hold;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    repeat (3) step();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    run_op(32'd5, 32'd7, 1'b0, 1'b0, d1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, d1);
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, d1);
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, d1);
    run_op(32'd3, 32'd3, 1'b1, 1'b0, d1);
    run_op(32'd0, 32'd1, 1'b1, 1'b0, d1);
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(1, 0)), 1'b0, d1);
    end

    // Start while busy is ignored and never yields a second done.
    run_op(32'd5, 32'd7, 1'b0, 1'b1, d1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      step();
    end
    check("ignored_start_dones", 64'(dones), 64'd0);

    // Reset in the middle of RUN aborts the operation.
    a = 32'd9; b = 32'd4; op_sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      step();
    end
    check("abort_dones", 64'(dones), 64'd0);

    // Back-to-back: run_op returns in the first IDLE cycle after done.
    run_op(32'h1234_5678, 32'h0000_1111, 1'b0, 1'b0, d1);
    hold = result;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, d2);
    check("b2b_spacing", 64'(d2 - d1), 64'(HALF + 2));
    check("b2b_first_result", 64'(hold), 64'h1234_6789);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
